mips32_dmem_responder: RTL
==========================

Name: mips32_dmem_responder

Overview:
- Memory-side responder for the MIPS32 pipeline's load/store port. Serves one word-addressed read or write at a time over a valid/ready request channel and a valid/ready response channel.
- Inserts a programmable number of wait cycles to model slow memory.
- The MEM stage is the initiator; this block owns the data array.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, request address width (word address, same units as PC/ALUOut)
- DEPTH, 1024, number of words in the array; valid addresses are 0..DEPTH-1
- LATENCY, 2, wait cycles between acceptance and response (0..15)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store (SW), 0 = load (LW)
- req_addr  input  ADDR_W  word address
- req_wdata  input  DATA_W  store data
- rsp_valid  output  1  response present
- rsp_ready  input  1  initiator accepts response
- rsp_rdata  output  DATA_W  load data (0 for stores and errors)
- rsp_err  output  1  address out of range

Behaviour:
- Reset (async assert, release synchronous to clk):
  - state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=0 while rst is high.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid&&req_ready, latch we/addr/wdata.
  - Go to WAIT with counter=LATENCY-1 if LATENCY>0; otherwise go directly to RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each edge; at counter==0 the next edge enters RESP.
- Entering RESP (the commit edge):
  - If addr>=DEPTH: rsp_err=1, rsp_rdata=0, no array write.
  - Otherwise, for a store: write array[addr]=wdata, rsp_rdata=0, rsp_err=0.
  - Otherwise, for a load: rsp_rdata=array[addr] (value before any write on the same edge), rsp_err=0.
- Latency: a request accepted at edge k has rsp_valid high starting edge k+1+LATENCY.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - The edge with rsp_valid&&rsp_ready returns to IDLE and clears rsp_valid, rsp_rdata and rsp_err.
  - rsp_ready low holds RESP indefinitely.
- Single outstanding request. The next acceptance is no earlier than the cycle after the response handshake, so peak throughput is one access per LATENCY+2 cycles.
- req_valid while req_ready=0 is ignored. The initiator must hold the request stable until accepted; the responder does not check this.
- Address compare uses the full ADDR_W value; there is no wrap modulo DEPTH.
- Reset mid-operation: a store still in WAIT is discarded and the array is unchanged. A store already committed (in RESP) remains written.
- LATENCY outside 0..15 is a fatal elaboration error.

Optional Feature:
- Macro: DMEM_BYTE_EN_EN.
- When defined:
  - Adds input req_be [DATA_W/8-1:0].
  - On a store, only byte lanes with req_be[i]=1 are updated; other lanes keep their old value.
  - A store with req_be=0 is a no-op write that still returns a normal response.
  - Loads ignore req_be.
- When undefined: no req_be port, and stores always write the full word.

Test Plan:
- Reset then idle:
  - After rst release, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - With rst held high, req_ready=0.
- Store then load, LATENCY=2, rsp_ready=1:
  - Store addr 5, data 32'hDEADBEEF: rsp_valid rises 3 edges after acceptance with rsp_rdata=0 and rsp_err=0.
  - Load addr 5: rsp_rdata=32'hDEADBEEF 3 edges after acceptance.
- Back-pressure:
  - Load addr 5 with rsp_ready=0 for 6 cycles: rsp_valid and rsp_rdata=32'hDEADBEEF stay stable and req_ready=0 throughout.
  - Raising rsp_ready gives IDLE on the next edge.
- Out of range, DEPTH=1024:
  - Store addr 1024, data 32'h1: rsp_err=1 and rsp_rdata=0.
  - A subsequent load of addr 0 is unchanged.
  - Load addr 32'hFFFFFFFF: rsp_err=1.
- Reset mid-operation with LATENCY=4:
  - Store addr 7, data 32'hA5A5A5A5; assert rst 2 cycles after acceptance.
  - After release, load addr 7 returns the pre-store value, and rsp_valid dropped immediately on rst.
- DMEM_BYTE_EN_EN with LATENCY=0:
  - Prefill addr 3=32'h11223344, then store 32'hAABBCCDD with req_be=4'b0101.
  - Load addr 3 returns 32'h11BB33DD; the response arrives 1 edge after acceptance.

Source files
------------

// File: rtl/mips32_dmem_responder.sv
// Word-addressed data-memory responder with valid/ready request and response channels and programmable wait cycles.
// Optional per-byte store enables when DMEM_BYTE_EN_EN is defined.
module mips32_dmem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_EN_EN
  input  logic [DATA_W/8-1:0] req_be,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BE_W  = DATA_W / 8;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  if ((LATENCY < 0) || (LATENCY > 15)) begin : g_bad_latency
    $fatal(1, "mips32_dmem_responder: LATENCY must be within 0..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              commit;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [BE_W-1:0]   c_be;
  logic              c_in_range;
  logic [IDX_W-1:0]  c_idx;
  logic [DATA_W-1:0] c_wmask;
  logic [BE_W-1:0]   in_be;

`ifdef DMEM_BYTE_EN_EN
  assign in_be = req_be;
`else
  assign in_be = '1;
`endif

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_valid && req_ready;

  // With zero latency the commit happens on the acceptance edge, so it works off the live request.
  always_comb begin
    if (LATENCY == 0) begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_be    = in_be;
    end else begin
      c_we    = we_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
      c_be    = be_q;
    end
  end

  assign c_in_range = (64'(c_addr) < 64'(DEPTH));
  assign c_idx      = c_addr[IDX_W-1:0];

  always_comb begin
    c_wmask = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      c_wmask[i*8 +: 8] = {8{c_be[i]}};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = in_be;
          if (LATENCY == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      err_d   = !c_in_range;
      rdata_d = (c_in_range && !c_we) ? mem_q[c_idx] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately not reset; commit is false while held in reset since state is IDLE.
  always_ff @(posedge clk) begin
    if (commit && c_we && c_in_range) begin
      mem_q[c_idx] <= (mem_q[c_idx] & ~c_wmask) | (c_wdata & c_wmask);
    end
  end

endmodule
